bv_priority_encoder: RTL and testbench

- Downstream of the half search engine. Consumes the ANDed rule bit-vector (bv_out_valid / bv_out) and resolves it to a single matching rule ID.
- Lowest set bit wins: rule 0 has the highest priority.
- The result feeds the action lookup stage.
- Also keeps lookup and miss statistics counters that the control plane can read.

---
 rtl/bv_priority_encoder_pkg.sv | 14 +
 rtl/bv_priority_encoder_pe_chunk.sv | 20 ++
 rtl/bv_priority_encoder.sv | 91 +++++++++
 tb/tb_bv_priority_encoder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bv_priority_encoder_pkg.sv
// Shared sizing constants for the bit-vector priority encoder.
// Width helpers live here so sub-modules and top agree on them.
package bv_priority_encoder_pkg;
  localparam int RULE_NUM_DEF = 128;
  localparam int CHUNK_W      = 32;
  localparam int STAT_W       = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/bv_priority_encoder_pe_chunk.sv
// Combinational lowest-set-bit finder for a W-bit slice.
// off is 0 when the slice is empty; qualify it with any.
module pe_chunk
  import bv_priority_encoder_pkg::*;
#(
  parameter int W     = CHUNK_W,
  parameter int OFF_W = (W > 1) ? clog2(W) : 1
) (
  input  logic [W-1:0]     bits,
  output logic             any,
  output logic [OFF_W-1:0] off
);
  always_comb begin
    any = |bits;
    off = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = W - 1; i >= 0; i--)
      if (bits[i]) off = OFF_W'(i);
  end
endmodule

// File: rtl/bv_priority_encoder.sv
// Three-stage priority encoder: lowest set rule bit wins, plus
// saturating lookup/miss statistics for the control plane.
module bv_priority_encoder
  import bv_priority_encoder_pkg::*;
#(
  parameter int RULE_NUM = RULE_NUM_DEF,
  parameter int CHUNK    = CHUNK_W,
  parameter int ID_W     = clog2(RULE_NUM)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bv_in_valid,
  input  logic [RULE_NUM-1:0] bv_in,
  input  logic                stat_clr,
  output logic                match_valid,
  output logic                match_hit,
  output logic [ID_W-1:0]     match_id,
  output logic [STAT_W-1:0]   lookup_cnt,
  output logic [STAT_W-1:0]   miss_cnt
);
  localparam int STAGES = 3;
  localparam int NCH    = RULE_NUM / CHUNK;
  localparam int OFF_W  = clog2(CHUNK);
  localparam int SEL_W  = (NCH > 1) ? clog2(NCH) : 1;
  localparam logic [STAT_W-1:0] SAT = '1;

  logic [STAGES:1] vld_pipe;

  // stage 1: per-slice any/offset
  logic [NCH-1:0]            any_c, any1;
  logic [NCH-1:0][OFF_W-1:0] off_c, off1;

  for (genvar k = 0; k < NCH; k++) begin : g_chunk
    pe_chunk #(.W(CHUNK), .OFF_W(OFF_W)) u_pe (
      .bits (bv_in[k*CHUNK +: CHUNK]),
      .any  (any_c[k]),
      .off  (off_c[k])
    );
  end

  // stage 2: pick the lowest non-empty slice
  logic             hit_s;
  logic [SEL_W-1:0] sel_s;
  logic             hit2;
  logic [ID_W-1:0]  id2;

  pe_chunk #(.W(NCH), .OFF_W(SEL_W)) u_sel (
    .bits (any1),
    .any  (hit_s),
    .off  (sel_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe    <= '0;
      any1        <= '0;
      off1        <= '0;
      hit2        <= 1'b0;
      id2         <= '0;
      match_hit   <= 1'b0;
      match_id    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bv_in_valid};
      any1     <= any_c;
      off1     <= off_c;
      hit2     <= hit_s;
      id2      <= hit_s ? ID_W'({sel_s, off1[sel_s]}) : '0;
      // Outputs hold between results; consumers only look on match_valid.
      if (vld_pipe[2]) begin
        match_hit <= hit2;
        match_id  <= id2;
      end
    end
  end

  assign match_valid = vld_pipe[STAGES];

  // Clear beats a same-cycle count; both counters stick at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lookup_cnt <= '0;
      miss_cnt   <= '0;
    end else if (stat_clr) begin
      lookup_cnt <= '0;
      miss_cnt   <= '0;
    end else if (vld_pipe[2]) begin
      if (lookup_cnt != SAT)        lookup_cnt <= lookup_cnt + 1'b1;
      if (!hit2 && miss_cnt != SAT) miss_cnt   <= miss_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_bv_priority_encoder.sv
// Scoreboard bench for bv_priority_encoder: expected results are queued
// at issue and popped when match_valid appears, latency checked too.
module tb_bv_priority_encoder;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         bv_in_valid = 1'b0;
  logic [127:0] bv_in = '0;
  logic         stat_clr = 1'b0;
  logic         match_valid, match_hit;
  logic [6:0]   match_id;
  logic [31:0]  lookup_cnt, miss_cnt;

  bv_priority_encoder dut (
    .clk         (clk),
    .reset       (reset),
    .bv_in_valid (bv_in_valid),
    .bv_in       (bv_in),
    .stat_clr    (stat_clr),
    .match_valid (match_valid),
    .match_hit   (match_hit),
    .match_id    (match_id),
    .lookup_cnt  (lookup_cnt),
    .miss_cnt    (miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hit;
    logic [6:0] id;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [127:0] v);
    exp_t e;
    e.hit = 1'b0;
    e.id  = '0;
    e.cyc = 0;
    for (int i = 0; i < 128; i++)
      if (v[i] && !e.hit) begin
        e.hit = 1'b1;
        e.id  = 7'(i);
      end
    return e;
  endfunction

  task automatic send(input logic [127:0] v);
    exp_t e;
    @(posedge clk);
    #1;
    bv_in_valid = 1'b1;
    bv_in       = v;
    e           = model(v);
    e.cyc       = cyc + 3;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bv_in_valid = 1'b0;
      bv_in       = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  function automatic logic [127:0] bit_vec(input int b);
    logic [127:0] one;
    one = 128'h1;
    return one << b;
  endfunction

  // Monitor: every match_valid must pair with the queue head at its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (match_valid) begin
      if (sbq.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("hit", 32'(match_hit), 32'(e.hit));
        chk("id", 32'(match_id), 32'(e.id));
        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      chk("missing_valid", 32'd0, 32'd1);
      void'(sbq.pop_front());
    end
  end

  initial begin
    logic [127:0] v;
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] v;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(match_valid), 32'd0);
    chk("rst_hit", 32'(match_hit), 32'd0);
    chk("rst_id", 32'(match_id), 32'd0);
    chk("rst_lookup", lookup_cnt, 32'd0);
    chk("rst_miss", miss_cnt, 32'd0);
    reset = 1'b1;

    // all-zero vector
    send('0);
    idle(4);
    chk("zero_lookup", lookup_cnt, 32'd1);
    chk("zero_miss", miss_cnt, 32'd1);

    // mixed, MSB only, all ones
    send(bit_vec(77) | bit_vec(100));
    idle(2);
    send(bit_vec(127));
    send('1);
    idle(4);
    chk("pat_lookup", lookup_cnt, 32'd4);
    chk("pat_miss", miss_cnt, 32'd1);

    // clear, then four back-to-back
    stat_clr = 1'b1;
    idle(1);
    stat_clr = 1'b0;
    chk("clr_lookup", lookup_cnt, 32'd0);
    send(bit_vec(5));
    send(bit_vec(40));
    send(bit_vec(96));
    send('0);
    idle(5);
    chk("b2b_lookup", lookup_cnt, 32'd4);
    chk("b2b_miss", miss_cnt, 32'd1);

    // saturation
    dut.lookup_cnt = 32'hFFFF_FFFE;
    repeat (3) begin
      v = {$urandom, $urandom, $urandom, $urandom} | bit_vec(int'($urandom_range(127)));
      send(v);
    end
    idle(5);
    chk("sat_lookup", lookup_cnt, 32'hFFFF_FFFF);
    chk("sat_miss", miss_cnt, 32'd1);

    // clear coincident with a miss result
    send('0);
    idle(2);
    stat_clr = 1'b1;
    idle(1);
    stat_clr = 1'b0;
    chk("clrhit_lookup", lookup_cnt, 32'd0);
    chk("clrhit_miss", miss_cnt, 32'd0);
    idle(3);
    chk("post_clr_lookup", lookup_cnt, 32'd0);

    // reset with two vectors in flight
    send(bit_vec(9));
    idle(4);
    chk("pre_rst_lookup", lookup_cnt, 32'd1);
    send(bit_vec(3));
    send(bit_vec(64));
    idle(1);
    reset = 1'b0;
    sbq.delete();
    idle(1);
    reset = 1'b1;
    idle(4);
    chk("inflight_lookup", lookup_cnt, 32'd0);
    chk("inflight_miss", miss_cnt, 32'd0);
    send(bit_vec(33) | bit_vec(90));
    idle(5);
    chk("fresh_lookup", lookup_cnt, 32'd1);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      v = ($urandom_range(3) == 0) ? '0 : bit_vec(int'($urandom_range(127)));
      if ($urandom_range(1)) v = v | bit_vec(int'($urandom_range(127)));
      if ($urandom_range(2) == 0) idle(1);
      send(v);
    end
    idle(6);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
